// File: rtl/pipe_stage_chain.sv
// Parametrised chain of pipeline registers with per-stage valid bits, hazard stall with
// bubble insertion, young-stage flush, output backpressure and saturating perf counters.

module pipe_stage_chain_sat_cnt #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc_i,
    output logic [CNT_W-1:0] count_o
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Saturate at all-ones instead of wrapping
    always_comb begin
        count_d = count_q;
        if (inc_i && (count_q != {CNT_W{1'b1}})) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

module pipe_stage_chain #(
    parameter int unsigned NUM_STAGES   = 4,
    parameter int unsigned DATA_W       = 64,
    parameter int unsigned STALL_STAGE  = 1,
    parameter int unsigned FLUSH_STAGES = 3,
    parameter int unsigned CNT_W        = 32
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             in_valid,
    input  logic [DATA_W-1:0]                in_data,
    output logic                             in_ready,
    input  logic                             stall_req,
    input  logic                             flush,
    output logic                             out_valid,
    output logic [DATA_W-1:0]                out_data,
    input  logic                             out_ready,
    output logic [NUM_STAGES-1:0]            stage_valid,
    output logic [NUM_STAGES*DATA_W-1:0]     stage_data,
    output logic [$clog2(NUM_STAGES+1)-1:0]  occupancy,
    output logic [CNT_W-1:0]                 stall_cycles,
    output logic [CNT_W-1:0]                 flush_count
);

    localparam int unsigned OCC_W = $clog2(NUM_STAGES + 1);

    logic [NUM_STAGES-1:0] valid_q;
    logic [NUM_STAGES-1:0] valid_d;
    logic [DATA_W-1:0]     data_q [NUM_STAGES];
    logic [DATA_W-1:0]     data_d [NUM_STAGES];

    logic hold_all;
    logic stall_eff;

    // Backpressure freezes everything; a stall is ignored while frozen or flushing
    always_comb begin
        hold_all  = valid_q[NUM_STAGES-1] & ~out_ready;
        stall_eff = stall_req & ~flush & ~hold_all;
        in_ready  = ~hold_all & ~stall_eff;
    end

    // Stage advance, bubble insertion and flush kill
    always_comb begin
        valid_d = valid_q;
        for (int unsigned i = 0; i < NUM_STAGES; i++) begin
            data_d[i] = data_q[i];
        end

        if (!hold_all) begin
            if (stall_eff) begin
                if (STALL_STAGE == 0) begin
                    valid_d[0] = 1'b0;
                end
            end else begin
                valid_d[0] = in_valid;
                data_d[0]  = in_data;
            end

            for (int unsigned i = 1; i < NUM_STAGES; i++) begin
                if (stall_eff && (i == STALL_STAGE)) begin
                    valid_d[i] = 1'b0;
                end else if (!stall_eff || (i > STALL_STAGE)) begin
                    valid_d[i] = valid_q[i-1];
                    data_d[i]  = data_q[i-1];
                end
            end
        end

        // Killed stages keep their stale payload; only the valid bit drops
        if (flush) begin
            for (int unsigned i = 0; i < FLUSH_STAGES; i++) begin
                valid_d[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            for (int unsigned i = 0; i < NUM_STAGES; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            for (int unsigned i = 0; i < NUM_STAGES; i++) begin
                data_q[i] <= data_d[i];
            end
        end
    end

    // Flattened per-stage views and occupancy popcount
    always_comb begin
        occupancy = '0;
        for (int unsigned i = 0; i < NUM_STAGES; i++) begin
            stage_data[i*DATA_W +: DATA_W] = data_q[i];
            occupancy = occupancy + OCC_W'(valid_q[i]);
        end
    end

    assign stage_valid = valid_q;
    assign out_valid   = valid_q[NUM_STAGES-1];
    assign out_data    = data_q[NUM_STAGES-1];

    pipe_stage_chain_sat_cnt #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk     (clk),
        .rst     (rst),
        .inc_i   (stall_eff),
        .count_o (stall_cycles)
    );

    pipe_stage_chain_sat_cnt #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk     (clk),
        .rst     (rst),
        .inc_i   (flush),
        .count_o (flush_count)
    );

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Scoreboard bench for pipe_stage_chain: 4 stages, 16-bit payload, 4-bit counters.

module tb_pipe_stage_chain;

    localparam int unsigned NS = 4;
    localparam int unsigned DW = 16;
    localparam int unsigned CW = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic [DW-1:0]     in_data;
    logic              in_ready;
    logic              stall_req;
    logic              flush;
    logic              out_valid;
    logic [DW-1:0]     out_data;
    logic              out_ready;
    logic [NS-1:0]     stage_valid;
    logic [NS*DW-1:0]  stage_data;
    logic [2:0]        occupancy;
    logic [CW-1:0]     stall_cycles;
    logic [CW-1:0]     flush_count;

    int n_checks = 0;
    int n_fail   = 0;
    int nxt      = 0;
    logic [DW-1:0] sb [$];

    pipe_stage_chain #(
        .NUM_STAGES(NS), .DATA_W(DW), .STALL_STAGE(1), .FLUSH_STAGES(3), .CNT_W(CW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .stall_req    (stall_req),
        .flush        (flush),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .out_ready    (out_ready),
        .stage_valid  (stage_valid),
        .stage_data   (stage_data),
        .occupancy    (occupancy),
        .stall_cycles (stall_cycles),
        .flush_count  (flush_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Output side pops the scoreboard; input side pushes each accepted, unflushed word
    always @(negedge clk) begin
        logic [63:0] exp;
        if (!rst) begin
            if (out_valid && out_ready) begin
                exp = (sb.size() > 0) ? 64'(sb.pop_front()) : 64'hDEAD_BEEF_DEAD_BEEF;
                check("out_data", 64'(out_data), exp);
            end
            if (in_valid && in_ready && !flush) sb.push_back(in_data);
        end
    end

    task automatic cycle();
        bit acc;
        @(negedge clk);
        acc = in_valid && in_ready && !flush && !rst;
        @(posedge clk);
        #1;
        if (acc) nxt++;
    endtask

    task automatic stream(input int n);
        repeat (n) begin
            in_valid = 1'b1;
            in_data  = DW'(nxt);
            cycle();
        end
    endtask

    task automatic drain(input string tag);
        in_valid = 1'b0;
        for (int k = 0; k < 30 && sb.size() != 0; k++) cycle();
        check(tag, 64'(sb.size()), 64'd0);
    endtask

    task automatic apply_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        stall_req = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #3;
        rst = 1'b0;
        sb.delete();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] full_chain(input int newest);
        return {DW'(newest-3), DW'(newest-2), DW'(newest-1), DW'(newest)};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        apply_reset();
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_occupancy", 64'(occupancy), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_stage_valid", 64'(stage_valid), 64'd0);
        check("rst_counters", {stall_cycles, flush_count}, 64'd0);

        // Stream and first-word latency
        nxt = 1;
        stream(3);
        check("lat_not_yet", 64'(out_valid), 64'd0);
        stream(1);
        check("lat_out_valid", 64'(out_valid), 64'd1);
        check("lat_out_data", 64'(out_data), 64'd1);
        check("steady_occ", 64'(occupancy), 64'd4);
        stream(6);

        // Single stall cycle inserts one bubble at stage 1
        stall_req = 1'b1;
        in_valid  = 1'b1;
        in_data   = DW'(nxt);
        #1;
        check("stall_in_ready", 64'(in_ready), 64'd0);
        cycle();
        stall_req = 1'b0;
        check("stall_bubble", 64'(stage_valid[1]), 64'd0);
        check("stall_cycles_1", 64'(stall_cycles), 64'd1);
        stream(2);
        check("stall_gap_out", 64'(out_valid), 64'd0);
        stream(4);
        drain("drain_stall");

        // Flush of a full chain 10..13
        apply_reset();
        nxt = 10;
        stream(4);
        check("pre_flush_full", stage_data, full_chain(13));
        flush    = 1'b1;
        in_valid = 1'b1;
        in_data  = DW'(nxt);
        #1;
        check("flush_in_ready", 64'(in_ready), 64'd1);
        cycle();
        flush = 1'b0;
        void'(sb.pop_back());
        void'(sb.pop_back());
        check("flush_valid", 64'(stage_valid), 64'b1000);
        check("flush_out_data", 64'(out_data), 64'd11);
        check("flush_occ", 64'(occupancy), 64'd1);
        check("flush_count_1", 64'(flush_count), 64'd1);
        drain("drain_flush");

        // Backpressure on a full chain; stall during hold is ignored
        stream(4);
        out_ready = 1'b0;
        stall_req = 1'b1;
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1;
            in_data  = DW'(nxt);
            #1;
            check("hold_in_ready", 64'(in_ready), 64'd0);
            cycle();
            check("hold_frozen", stage_data, full_chain(nxt-1));
            check("hold_valid", 64'(stage_valid), 64'hF);
        end
        check("hold_no_stall_cnt", 64'(stall_cycles), 64'd0);
        stall_req = 1'b0;
        out_ready = 1'b1;
        stream(4);

        // Flush + stall + hold together
        flush     = 1'b1;
        stall_req = 1'b1;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = DW'(nxt);
        #1;
        check("fsh_in_ready", 64'(in_ready), 64'd0);
        cycle();
        flush     = 1'b0;
        stall_req = 1'b0;
        repeat (3) void'(sb.pop_back());
        check("fsh_valid", 64'(stage_valid), 64'b1000);
        check("fsh_stage3", 64'(out_data), 64'(DW'(nxt-4)));
        check("fsh_flush_count", 64'(flush_count), 64'd2);
        check("fsh_stall_cycles", 64'(stall_cycles), 64'd0);
        out_ready = 1'b1;
        drain("drain_fsh");

        // Stall counter saturation, then asynchronous mid-cycle reset
        apply_reset();
        nxt = 100;
        stream(4);
        stall_req = 1'b1;
        stream(10);
        check("stall_cnt_10", 64'(stall_cycles), 64'd10);
        stream(10);
        check("stall_cnt_sat", 64'(stall_cycles), 64'd15);
        stall_req = 1'b0;
        stream(3);
        flush = 1'b1;
        stream(1);
        flush = 1'b0;
        stream(3);
        #2;
        rst      = 1'b1;
        in_valid = 1'b0;
        #1;
        check("arst_valid", 64'(stage_valid), 64'd0);
        check("arst_occ", 64'(occupancy), 64'd0);
        check("arst_counters", {stall_cycles, flush_count}, 64'd0);
        sb.delete();
        @(posedge clk);
        #3;
        rst = 1'b0;
        @(posedge clk);
        #1;
        nxt = 200;
        stream(6);
        drain("drain_final");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
